// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and default sizes for the register file
// Purpose: clear-sequencer state type and default configuration constants.
// Ports: none (package).
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - sequential clear engine for the register file
// Purpose: sweeps entries 1..2**ADDR_W-1, writing zero one entry per cycle.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (starts a sweep)
//   clr           - one-cycle request to start a sweep (ignored mid-sweep)
//   busy          - high while the sweep is running
//   clr_we        - clear-write strobe into the array
//   clr_addr      - entry being cleared this cycle
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (rst) begin
      state_d = CLEAR;
      ptr_d   = ADDR_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_d = CLEAR;
            ptr_d   = ADDR_W'(1);
          end
        end
        CLEAR: begin
          ptr_d = ptr_q + ADDR_W'(1);
          // Last entry cleared this edge; entry 0 is never visited.
          if (ptr_q == '1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-read-port register file, r0 hardwired to zero
// Purpose: 2**ADDR_W x DATA_W array, one write port, NUM_RD combinational read ports,
//          hardware clear sweep after reset or on Clr.
// Option: RF_BYPASS_EN - forward an accepted write to matching read ports in the same cycle.
// Ports:
//   Clk, Rst      - clock, synchronous active-high reset
//   Ard / Dout    - packed read addresses / read data, port k at [k*W +: W]
//   Awr, Din, WrEn- write port
//   Clr           - start a clear sweep
//   Busy          - clear sweep in progress (all reads return 0)
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*ADDR_W-1:0] Ard,
  output logic [NUM_RD*DATA_W-1:0] Dout,
  input  logic [ADDR_W-1:0]        Awr,
  input  logic [DATA_W-1:0]        Din,
  input  logic                     WrEn,
  input  logic                     Clr,
  output logic                     Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              usr_we;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk      (Clk),
    .rst      (Rst),
    .clr      (Clr),
    .busy     (Busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A user write survives only in IDLE with no competing reset or clear request.
  assign usr_we = WrEn && !Busy && !Clr && !Rst && (Awr != '0);

  always_comb begin
    mem_d = mem_q;
    if (clr_we)      mem_d[clr_addr] = '0;
    else if (usr_we) mem_d[Awr]      = Din;
  end

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              fwd;
    logic [DATA_W-1:0] rd_data;

    assign rd_addr = Ard[g*ADDR_W +: ADDR_W];

`ifdef RF_BYPASS_EN
    assign fwd = usr_we && (Awr == rd_addr);
`else
    assign fwd = 1'b0;
`endif

    // The array is logically reset while the sweep runs, so reads return 0.
    always_comb begin
      rd_data = '0;
      if (!Busy) begin
        if (fwd)                  rd_data = Din;
        else if (rd_addr != '0)   rd_data = mem_q[rd_addr];
      end
    end

    assign Dout[g*DATA_W +: DATA_W] = rd_data;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized self-checking bench for reg_file_mp
module tb_reg_file_mp;

  logic        Clk = 1'b0;
  logic        Rst, WrEn, Clr, Busy;
  logic [9:0]  Ard;
  logic [63:0] Dout;
  logic [4:0]  Awr;
  logic [31:0] Din;

  logic        p_rst, p_we, p_clr, p_busy;
  logic [8:0]  p_ard;
  logic [47:0] p_dout;
  logic [2:0]  p_awr;
  logic [15:0] p_din;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] mem_m [32];
  int          busy_left = 0;
  bit          chk_en = 1'b0;
  logic        busy_obs;

  always #5 Clk = ~Clk;

  reg_file_mp dut (
    .Clk(Clk), .Rst(Rst), .Ard(Ard), .Dout(Dout), .Awr(Awr),
    .Din(Din), .WrEn(WrEn), .Clr(Clr), .Busy(Busy)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) dut_p (
    .Clk(Clk), .Rst(p_rst), .Ard(p_ard), .Dout(p_dout), .Awr(p_awr),
    .Din(p_din), .WrEn(p_we), .Clr(p_clr), .Busy(p_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (busy_left > 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (WrEn && !Clr && !Rst && Awr != 5'd0 && Awr == a) return Din;
`endif
    if (a == 5'd0) return 32'h0;
    return mem_m[a];
  endfunction

  task automatic model_clear();
    busy_left = 31;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
  endtask

  task automatic tick();
    @(negedge Clk);
    if (chk_en) begin
      check_eq("busy", {31'h0, Busy}, {31'h0, busy_left > 0});
      for (int k = 0; k < 2; k++)
        check_eq($sformatf("dout%0d", k), Dout[k*32 +: 32], exp_rd(Ard[k*5 +: 5]));
    end
    busy_obs = Busy;
    @(posedge Clk);
    if (Rst) model_clear();
    else if (busy_left > 0) busy_left--;
    else if (Clr) model_clear();
    else if (WrEn && Awr != 5'd0) mem_m[Awr] = Din;
    #1;
  endtask

  task automatic idle_inputs();
    WrEn = 1'b0; Clr = 1'b0; Rst = 1'b0;
  endtask

  task automatic count_busy(input bit noise, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      Ard = 10'($urandom);
      if (noise && busy_left > 1) begin
        WrEn = 1'($urandom); Awr = 5'($urandom); Din = $urandom;
        Clr  = ($urandom_range(0, 3) == 0);
      end else begin
        idle_inputs();
      end
      tick();
      if (busy_obs) n++;
      else break;
    end
    idle_inputs();
  endtask

  task automatic settle();
    idle_inputs();
    for (int i = 0; i < 64 && busy_left > 0; i++) tick();
    check_eq("settle", {31'h0, busy_left > 0}, 32'h0);
  endtask

  int n;

  initial begin
    Rst = 1'b1; WrEn = 1'b0; Clr = 1'b0; Ard = '0; Awr = '0; Din = '0;
    p_rst = 1'b1; p_we = 1'b0; p_clr = 1'b0; p_ard = '0; p_awr = '0; p_din = '0;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;

    // Reset held two edges, then released.
    tick();
    chk_en = 1'b1;
    tick();
    Rst = 1'b0;
    count_busy(1'b0, n);
    check_eq("rst_busy_len", n, 31);

    // Write then read on both ports.
    WrEn = 1'b1; Awr = 5'd7; Din = 32'hDEADBEEF; Ard = {5'd7, 5'd7};
    tick();
    WrEn = 1'b0;
    check_eq("rd7_p0", Dout[31:0], 32'hDEADBEEF);
    check_eq("rd7_p1", Dout[63:32], 32'hDEADBEEF);
    tick();

    // Write to register 0 is discarded.
    WrEn = 1'b1; Awr = 5'd0; Din = 32'h12345678; Ard = {5'd0, 5'd0};
    tick();
    WrEn = 1'b0;
    check_eq("rd0", Dout[31:0], 32'h0);
    tick();

    // Same-cycle forwarding (or old value without it).
    WrEn = 1'b1; Awr = 5'd9; Din = 32'hA5A5A5A5; Ard = {5'd7, 5'd9};
    #2;
`ifdef RF_BYPASS_EN
    check_eq("byp_same", Dout[31:0], 32'hA5A5A5A5);
`else
    check_eq("byp_same", Dout[31:0], 32'h0);
`endif
    check_eq("byp_other", Dout[63:32], 32'hDEADBEEF);
    tick();
    WrEn = 1'b0;
    check_eq("byp_next", Dout[31:0], 32'hA5A5A5A5);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 600; i++) begin
      WrEn = 1'($urandom); Awr = 5'($urandom); Din = $urandom; Ard = 10'($urandom);
      Clr  = ($urandom_range(0, 39) == 0);
      Rst  = ($urandom_range(0, 149) == 0);
      tick();
    end
    settle();

    // Fill every entry, then Clr racing a write to 3.
    for (int a = 1; a < 32; a++) begin
      WrEn = 1'b1; Awr = 5'(a); Din = $urandom | 32'h1; Ard = 10'($urandom);
      tick();
    end
    Clr = 1'b1; WrEn = 1'b1; Awr = 5'd3; Din = 32'hFFFF0000;
    tick();
    Clr = 1'b0; WrEn = 1'b0;
    count_busy(1'b1, n);
    check_eq("clr_busy_len", n, 31);
    for (int a = 0; a < 32; a++) begin
      Ard = {5'(a), 5'(a)};
      #1;
      check_eq($sformatf("clr_zero%0d", a), Dout[31:0], 32'h0);
      tick();
    end

    // Reset arriving mid-sweep restarts it; Clr pulses do not extend it.
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    count_busy(1'b1, n);
    check_eq("rst_mid_len", n, 31);
    settle();

    // Small configuration: 16-bit, 8 entries, 3 read ports.
    p_rst = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    p_rst = 1'b0;
    p_ard = {3'd7, 3'd2, 3'd1};
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (i == 0) check_eq("p_sweep_rd", p_dout[31:0], 32'h0);
      if (!p_busy) break;
      n++;
      @(posedge Clk); #1;
    end
    check_eq("p_busy_len", n, 7);
    @(posedge Clk); #1;
    p_we = 1'b1; p_awr = 3'd1; p_din = 16'h1111;
    @(posedge Clk); #1;
    p_awr = 3'd2; p_din = 16'h2222;
    @(posedge Clk); #1;
    p_awr = 3'd7; p_din = 16'h7777;
    @(posedge Clk); #1;
    p_we = 1'b0;
    #1;
    check_eq("p_port0", {16'h0, p_dout[15:0]}, 32'h1111);
    check_eq("p_port1", {16'h0, p_dout[31:16]}, 32'h2222);
    check_eq("p_port2", {16'h0, p_dout[47:32]}, 32'h7777);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
